// File: rtl/serial_rx_deser_pkg.sv
// Shared types and constants for the serial receive deserializer.
package serial_rx_pkg;

    // Legal range for the deserialized word width.
    localparam int DATA_W_MIN = 2;
    localparam int DATA_W_MAX = 32;

    // Frame receive states. PARITY is only reachable in the parity build.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } rx_state_e;

endpackage

// File: rtl/serial_rx_deser_if.sv
// Serial receive bus: strobe + serial bit in, deserialized word and status pulses out.
interface serial_rx_deser_if #(
    parameter int DATA_W = 8
);
    logic              valid;
    logic              Data_in;
    logic [DATA_W-1:0] RxReg_out;
    logic              rx_done;
    logic              rx_err;

    // Driver side (feeds the serial stream, observes results).
    modport master (
        output valid,
        output Data_in,
        input  RxReg_out,
        input  rx_done,
        input  rx_err
    );

    // Deserializer side.
    modport slave (
        input  valid,
        input  Data_in,
        output RxReg_out,
        output rx_done,
        output rx_err
    );
endinterface

// File: rtl/serial_rx_deser_rx_shift_reg.sv
// Shift register for serial_rx_deser. word_nxt is the value the register will
// hold after this edge, so the owner can capture a completed word on the same
// edge that samples its last bit.
module rx_shift_reg #(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clr,
    input  logic              shift_en,
    input  logic              bit_in,
    output logic [DATA_W-1:0] word_nxt
);

    logic [DATA_W-1:0] sr_q;
    logic [DATA_W-1:0] shifted;

    // MSB-first shifts left so the first bit ends up at the top; LSB-first
    // shifts right so the first bit ends up in bit 0.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign shifted = {sr_q[DATA_W-2:0], bit_in};
        end else begin : g_lsb_first
            assign shifted = {bit_in, sr_q[DATA_W-1:1]};
        end
    endgenerate

    assign word_nxt = shift_en ? shifted : sr_q;

    // Shift register: cleared on every frame start, shifts one bit per data edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sr_q <= '0;
        end else if (clr) begin
            sr_q <= '0;
        end else if (shift_en) begin
            sr_q <= shifted;
        end
    end

endmodule

// File: rtl/serial_rx_deser.sv
// Serial-to-parallel receiver. A valid strobe marks the start bit; the next
// DATA_W bits are collected and loaded into RxReg_out on the edge that samples
// the last one. A valid strobe mid-frame aborts and restarts the frame.
// Optional feature: define SERIAL_RX_PARITY_EN to append one even-parity bit
// per frame, checked before the word is accepted.
module serial_rx_deser
    import serial_rx_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    serial_rx_deser_if.slave  bus
);

    localparam int               CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);

    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rx_q;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              load;
    logic              sr_clr;
    logic              sr_en;
    logic [DATA_W-1:0] word;

    rx_shift_reg #(
        .DATA_W    (DATA_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clock    (clock),
        .reset    (reset),
        .clr      (sr_clr),
        .shift_en (sr_en),
        .bit_in   (bus.Data_in),
        .word_nxt (word)
    );

    // State, bit counter, output word and status pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rx_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (load) begin
                rx_q <= word;
            end
        end
    end

    // Next-state logic: frame start, bit collection, resync on mid-frame valid.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        load    = 1'b0;
        sr_clr  = 1'b0;
        sr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.valid) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    sr_clr  = 1'b1;
                end
            end
            SHIFT: begin
                if (bus.valid) begin
                    // Restart: this edge is the new frame's start marker.
                    err_d  = 1'b1;
                    cnt_d  = '0;
                    sr_clr = 1'b1;
                end else begin
                    sr_en = 1'b1;
                    if (cnt_q == LAST) begin
                        cnt_d = '0;
`ifdef SERIAL_RX_PARITY_EN
                        state_d = PARITY;
`else
                        load    = 1'b1;
                        done_d  = 1'b1;
                        state_d = IDLE;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            PARITY: begin
                if (bus.valid) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    sr_clr  = 1'b1;
                    state_d = SHIFT;
                end else begin
                    // Even parity: data bits plus parity bit must XOR to zero.
                    state_d = IDLE;
                    if (^{word, bus.Data_in} == 1'b0) begin
                        load   = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.RxReg_out = rx_q;
    assign bus.rx_done   = done_q;
    assign bus.rx_err    = err_q;

endmodule

// File: tb/tb_serial_rx_deser.sv
// Self-checking bench for serial_rx_deser: three instances (8-bit LSB-first,
// 8-bit MSB-first, 16-bit LSB-first) share one serial stream. A frame-level
// reference model predicts every cycle; a vector table and directed sequences
// add fixed expectations.
module tb_serial_rx_deser;

`ifdef SERIAL_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tv  = 1'b0;
    logic td  = 1'b0;

    always #5 clk = ~clk;

    serial_rx_deser_if #(.DATA_W(8))  b0 ();
    serial_rx_deser_if #(.DATA_W(8))  b1 ();
    serial_rx_deser_if #(.DATA_W(16)) b2 ();

    assign b0.valid = tv; assign b0.Data_in = td;
    assign b1.valid = tv; assign b1.Data_in = td;
    assign b2.valid = tv; assign b2.Data_in = td;

    serial_rx_deser #(.DATA_W(8),  .MSB_FIRST(1'b0)) u0 (.clock(clk), .reset(rst), .bus(b0));
    serial_rx_deser #(.DATA_W(8),  .MSB_FIRST(1'b1)) u1 (.clock(clk), .reset(rst), .bus(b1));
    serial_rx_deser #(.DATA_W(16), .MSB_FIRST(1'b0)) u2 (.clock(clk), .reset(rst), .bus(b2));

    int n_tests = 0;
    int n_fail  = 0;
    int dcnt [3];

    // ---------------- reference model (frame level) ----------------
    int          mw   [3] = '{8, 8, 16};
    bit          mmsb [3] = '{1'b0, 1'b1, 1'b0};
    bit          m_in [3];
    int          m_pos[3];
    int          m_ones[3];
    logic [31:0] m_word[3];
    logic [31:0] m_out[3];
    bit          m_done[3];
    bit          m_err[3];

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_in[k] = 0; m_pos[k] = 0; m_ones[k] = 0; m_word[k] = '0;
            m_out[k] = '0; m_done[k] = 0; m_err[k] = 0;
        end
    endtask

    task automatic model_edge(input bit v, input bit d);
        for (int k = 0; k < 3; k++) begin
            m_done[k] = 0;
            m_err[k]  = 0;
            if (v) begin
                if (m_in[k]) m_err[k] = 1;
                m_in[k] = 1; m_pos[k] = 0; m_ones[k] = 0; m_word[k] = '0;
            end else if (m_in[k]) begin
                if (m_pos[k] < mw[k]) begin
                    if (d) begin
                        int idx;
                        idx = mmsb[k] ? (mw[k] - 1 - m_pos[k]) : m_pos[k];
                        m_word[k] = m_word[k] | (32'd1 << idx);
                        m_ones[k]++;
                    end
                    m_pos[k]++;
                    if (m_pos[k] == mw[k] && !PAR) begin
                        m_out[k] = m_word[k]; m_done[k] = 1; m_in[k] = 0;
                    end
                end else begin
                    if (((m_ones[k] + int'(d)) % 2) == 0) begin
                        m_out[k] = m_word[k]; m_done[k] = 1;
                    end else begin
                        m_err[k] = 1;
                    end
                    m_in[k] = 0;
                end
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    function automatic logic [31:0] a_out(int k);
        case (k)
            0:       return 32'(b0.RxReg_out);
            1:       return 32'(b1.RxReg_out);
            default: return 32'(b2.RxReg_out);
        endcase
    endfunction

    function automatic logic [1:0] a_st(int k);
        case (k)
            0:       return {b0.rx_done, b0.rx_err};
            1:       return {b1.rx_done, b1.rx_err};
            default: return {b2.rx_done, b2.rx_err};
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm);
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (a_out(k) !== m_out[k] || a_st(k) !== {m_done[k], m_err[k]}) begin
                n_fail++;
                $display("FAIL %s dut%0d out=%h exp=%h done/err=%b exp=%b%b @%0t",
                         nm, k, a_out(k), m_out[k], a_st(k), m_done[k], m_err[k], $time);
            end
        end
    endtask

    // One clock: drive inputs, advance model at the edge, compare on the falling edge.
    task automatic step(input bit v, input bit d);
        tv = v; td = d;
        @(posedge clk);
        model_edge(v, d);
        @(negedge clk);
        chk_all("model");
        for (int k = 0; k < 3; k++) dcnt[k] += int'(a_st(k) >> 1);
    endtask

    // Start marker, n data bits in transmit order w[0]..w[n-1], then even parity if built.
    task automatic send_frame(input logic [31:0] w, input int n);
        bit p;
        p = 0;
        step(1'b1, 1'b0);
        for (int i = 0; i < n; i++) begin
            step(1'b0, w[i]);
            p ^= w[i];
        end
        if (PAR) step(1'b0, p);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit         v;
        bit         d;
        bit         done;
        bit         err;
        logic [7:0] out0;
        logic [7:0] out1;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit v, input bit d, input bit dn, input bit er,
                       input logic [7:0] o0, input logic [7:0] o1);
        vec_t r;
        r.v = v; r.d = d; r.done = dn; r.err = er; r.out0 = o0; r.out1 = o1;
        tbl.push_back(r);
    endtask

    initial begin
        logic [31:0] w;
        int d0, de;

        for (int k = 0; k < 3; k++) dcnt[k] = 0;
        model_reset();

        // Reset state while reset is held.
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("reset_out", a_out(k), 32'h0);
            chk("reset_flags", 32'(a_st(k)), 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;

`ifndef SERIAL_RX_PARITY_EN
        // 0x55 frame, back-to-back start, abort after 4 bits, then 0x0F.
        add(1, 0, 0, 0, 8'h00, 8'h00);
        add(0, 1, 0, 0, 8'h00, 8'h00); add(0, 0, 0, 0, 8'h00, 8'h00);
        add(0, 1, 0, 0, 8'h00, 8'h00); add(0, 0, 0, 0, 8'h00, 8'h00);
        add(0, 1, 0, 0, 8'h00, 8'h00); add(0, 0, 0, 0, 8'h00, 8'h00);
        add(0, 1, 0, 0, 8'h00, 8'h00); add(0, 0, 1, 0, 8'h55, 8'hAA);
        add(1, 0, 0, 0, 8'h55, 8'hAA);
        add(0, 1, 0, 0, 8'h55, 8'hAA); add(0, 1, 0, 0, 8'h55, 8'hAA);
        add(0, 1, 0, 0, 8'h55, 8'hAA); add(0, 1, 0, 0, 8'h55, 8'hAA);
        add(1, 0, 0, 1, 8'h55, 8'hAA);
        add(0, 1, 0, 0, 8'h55, 8'hAA); add(0, 1, 0, 0, 8'h55, 8'hAA);
        add(0, 1, 0, 0, 8'h55, 8'hAA); add(0, 1, 0, 0, 8'h55, 8'hAA);
        add(0, 0, 0, 0, 8'h55, 8'hAA); add(0, 0, 0, 0, 8'h55, 8'hAA);
        add(0, 0, 0, 0, 8'h55, 8'hAA); add(0, 0, 1, 0, 8'h0F, 8'hF0);
        add(0, 1, 0, 0, 8'h0F, 8'hF0);
`else
        // 0x55 with good parity bit, then 0x55 with bad parity bit.
        add(1, 0, 0, 0, 8'h00, 8'h00);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 8; i++)
                add(0, (i % 2 == 0), 0, 0, (r == 0) ? 8'h00 : 8'h55, (r == 0) ? 8'h00 : 8'hAA);
            if (r == 0) begin
                add(0, 0, 1, 0, 8'h55, 8'hAA);
                add(1, 0, 0, 0, 8'h55, 8'hAA);
            end else begin
                add(0, 1, 0, 1, 8'h55, 8'hAA);
            end
        end
`endif
        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].d);
            chk("tbl_done0", 32'(b0.rx_done), 32'(tbl[i].done));
            chk("tbl_done1", 32'(b1.rx_done), 32'(tbl[i].done));
            chk("tbl_err0",  32'(b0.rx_err),  32'(tbl[i].err));
            chk("tbl_out0",  32'(b0.RxReg_out), 32'(tbl[i].out0));
            chk("tbl_out1",  32'(b1.RxReg_out), 32'(tbl[i].out1));
        end
        step(1'b0, 1'b0);

        // Back-to-back frames: 0x55 pattern then all ones, no idle gap.
        d0 = dcnt[1];
        send_frame(32'h55, 8);
        chk("b2b_first_out1", a_out(1), 32'hAA);
        send_frame(32'hFF, 8);
        chk("b2b_pulses1", 32'(dcnt[1] - d0), 32'd2);
        chk("b2b_out1", a_out(1), 32'hFF);
        chk("b2b_out0", a_out(0), 32'hFF);

        // Asynchronous reset mid-frame, between clock edges.
        step(1'b1, 1'b0);
        step(1'b0, 1'b1); step(1'b0, 1'b0); step(1'b0, 1'b1);
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_async_out", a_out(k), 32'h0);
            chk("rst_async_flags", 32'(a_st(k)), 32'h0);
        end
        #1 rst = 1'b0;
        model_reset();
        de = dcnt[0];
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        chk("rst_no_done", 32'(dcnt[0] - de), 32'd0);
        chk("rst_no_err", 32'(b0.rx_err), 32'd0);
        send_frame(32'h3C, 8);
        chk("rst_frame_out0", a_out(0), 32'h3C);

        // 16-bit frame: word appears exactly on the last data (or parity) edge.
        w = 32'hA5C3;
        step(1'b1, 1'b0);
        for (int i = 0; i < 15; i++) step(1'b0, w[i]);
        chk("w16_early_done", 32'(b2.rx_done), 32'd0);
        step(1'b0, w[15]);
        if (PAR) begin
            chk("w16_par_wait", 32'(b2.rx_done), 32'd0);
            step(1'b0, 1'b0);
        end
        chk("w16_done", 32'(b2.rx_done), 32'd1);
        chk("w16_out", a_out(2), 32'hA5C3);
        step(1'b0, 1'b0);
        chk("w16_done_pulse", 32'(b2.rx_done), 32'd0);

        // Random streams against the reference model.
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 11) == 0, 1'($urandom_range(0, 1)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
